// File: rtl/song_transport_ctrl.sv
// Transport controller for the note sequencer: tempo strobe, loop-window step index,
// and registered arbitration of the tone period between song lookup and live key.
module song_transport_ctrl #(
  parameter int IDX_W         = 9,
  parameter int TEMPO_W       = 24,
  parameter int TEMPO_DEFAULT = 12500000
) (
  input  logic               clk50,
  input  logic               reset,
  input  logic               cmd_play,
  input  logic               cmd_pause,
  input  logic               cmd_stop,
  input  logic               loop_en,
  input  logic [IDX_W-1:0]   loop_start,
  input  logic [IDX_W-1:0]   loop_end,
  input  logic [TEMPO_W-1:0] tempo_period,
  input  logic               tempo_load,
  input  logic [15:0]        song_tone,
  input  logic               key_req,
  input  logic [15:0]        key_tone,
  output logic [IDX_W-1:0]   note_idx,
  output logic               step_strobe,
  output logic [15:0]        tone_out,
  output logic               tone_src,
  output logic [1:0]         state
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;

  localparam logic [TEMPO_W-1:0] PER_DEF = TEMPO_W'(TEMPO_DEFAULT);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, start_q, start_d, end_q, end_d;
  logic [TEMPO_W-1:0] cnt_q, cnt_d, per_q, per_d, shadow_q, shadow_d, ld_val;
  logic               strobe_q, strobe_d, src_q, src_d;
  logic [15:0]        tone_q, tone_d;
  logic               boundary;

  assign ld_val   = (tempo_period < TEMPO_W'(2)) ? TEMPO_W'(2) : tempo_period;
  assign boundary = (cnt_q == per_q - TEMPO_W'(1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    start_d  = start_q;
    end_d    = end_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    shadow_d = shadow_q;
    strobe_d = 1'b0;
    src_d    = key_req;
    tone_d   = key_req ? key_tone : ((state_q == PLAY) ? song_tone : 16'h0000);

    // Outside a running song the new tempo applies at once; otherwise at the next step.
    if (tempo_load) begin
      shadow_d = ld_val;
      if (state_q == IDLE || state_q == DONE) per_d = ld_val;
    end

    if (cmd_stop) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    end else if (cmd_pause) begin
      if (state_q == PLAY) state_d = PAUSE;
    end else if (cmd_play && (state_q == IDLE || state_q == DONE)) begin
      if (loop_start <= loop_end) begin
        start_d = loop_start;
        end_d   = loop_end;
        idx_d   = loop_start;
        cnt_d   = '0;
        state_d = PLAY;
      end
    end else if (cmd_play && state_q == PAUSE) begin
      state_d = PLAY;
    end else if (state_q == PLAY) begin
      if (boundary) begin
        cnt_d    = '0;
        strobe_d = 1'b1;
        per_d    = tempo_load ? ld_val : shadow_q;
        if (idx_q == end_q) begin
          if (loop_en) idx_d = start_q;
          else         state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        cnt_d = cnt_q + TEMPO_W'(1);
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      start_q  <= '0;
      end_q    <= '0;
      cnt_q    <= '0;
      per_q    <= PER_DEF;
      shadow_q <= PER_DEF;
      strobe_q <= 1'b0;
      src_q    <= 1'b0;
      tone_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      end_q    <= end_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      shadow_q <= shadow_d;
      strobe_q <= strobe_d;
      src_q    <= src_d;
      tone_q   <= tone_d;
    end
  end

  assign note_idx    = idx_q;
  assign step_strobe = strobe_q;
  assign tone_out    = tone_q;
  assign tone_src    = src_q;
  assign state       = state_q;
endmodule

// File: tb/tb_song_transport_ctrl.sv
// Bench for song_transport_ctrl: directed scenarios plus random traffic, all checked
// against a countdown-based transport model kept in the bench.
module tb_song_transport_ctrl;
  localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

  logic        clk50 = 1'b0;
  logic        reset, cmd_play, cmd_pause, cmd_stop, loop_en, tempo_load, key_req;
  logic [8:0]  loop_start, loop_end, note_idx;
  logic [23:0] tempo_period;
  logic [15:0] song_tone, key_tone, tone_out;
  logic        step_strobe, tone_src, song_fixed;
  logic [1:0]  state;
  logic [28:0] dut_vec;

  int n_cmp = 0;
  int n_err = 0;

  song_transport_ctrl dut (
    .clk50(clk50), .reset(reset), .cmd_play(cmd_play), .cmd_pause(cmd_pause),
    .cmd_stop(cmd_stop), .loop_en(loop_en), .loop_start(loop_start), .loop_end(loop_end),
    .tempo_period(tempo_period), .tempo_load(tempo_load), .song_tone(song_tone),
    .key_req(key_req), .key_tone(key_tone), .note_idx(note_idx), .step_strobe(step_strobe),
    .tone_out(tone_out), .tone_src(tone_src), .state(state)
  );

  always #5 clk50 = ~clk50;

  assign song_tone = song_fixed ? 16'h1234 : (16'h0100 + {7'd0, note_idx});
  assign dut_vec   = {state, note_idx, step_strobe, tone_out, tone_src};

  // Reference model: a step is a countdown of 'mrem' play cycles.
  logic [1:0]  ms;
  logic [8:0]  midx, mstart, mend;
  logic        mstb, msrc;
  logic [15:0] mtone;
  int unsigned mrem, mper, mshadow;

  function automatic logic [15:0] songf(input logic [8:0] i);
    return song_fixed ? 16'h1234 : (16'h0100 + {7'd0, i});
  endfunction

  function automatic logic [28:0] exp_vec();
    return {ms, midx, mstb, mtone, msrc};
  endfunction

  task automatic model_step();
    if (reset) begin
      ms = S_IDLE; midx = 0; mstart = 0; mend = 0; mstb = 0; msrc = 0; mtone = 0;
      mrem = 0; mper = 12500000; mshadow = 12500000;
    end else begin
      mtone = key_req ? key_tone : ((ms == S_PLAY) ? songf(midx) : 16'h0000);
      msrc  = key_req;
      mstb  = 0;
      if (tempo_load) begin
        mshadow = (tempo_period < 2) ? 2 : int'(tempo_period);
        if (ms == S_IDLE || ms == S_DONE) mper = mshadow;
      end
      if (cmd_stop) begin
        if (ms != S_IDLE) begin ms = S_IDLE; midx = 0; end
      end else if (cmd_pause) begin
        if (ms == S_PLAY) ms = S_PAUSE;
      end else if (cmd_play && (ms == S_IDLE || ms == S_DONE)) begin
        if (loop_start <= loop_end) begin
          mstart = loop_start; mend = loop_end; midx = loop_start; mrem = mper; ms = S_PLAY;
        end
      end else if (cmd_play && ms == S_PAUSE) begin
        ms = S_PLAY;
      end else if (ms == S_PLAY) begin
        mrem--;
        if (mrem == 0) begin
          mstb = 1; mper = mshadow; mrem = mper;
          if (midx == mend) begin
            if (loop_en) midx = mstart;
            else         ms = S_DONE;
          end else midx = midx + 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    model_step();
    #1;
    cmd_play = 0; cmd_pause = 0; cmd_stop = 0; tempo_load = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); reset = 0;
    n_cmp++;
    if (dut_vec !== 29'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
    end
    tempo_period = 24'd4; tempo_load = 1; tick();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL reset_tempo_load: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_loop();
    int seq[$];
    int last = 0, gaps_bad = 0;
    loop_start = 1; loop_end = 3; loop_en = 1; cmd_play = 1; tick();
    n_cmp++;
    if (state !== S_PLAY || note_idx !== 9'd1) begin
      n_err++; $display("FAIL loop_start: state=%0d idx=%0d want 1/1", state, note_idx);
    end
    for (int c = 1; c <= 20; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL loop_cycle%0d: got %h want %h", c, dut_vec, exp_vec());
      end
      if (step_strobe) begin
        seq.push_back(int'(note_idx));
        if (c - last != 4) gaps_bad++;
        last = c;
      end
    end
    n_cmp++;
    if (seq.size() != 5 || seq[0] != 2 || seq[1] != 3 || seq[2] != 1 || seq[3] != 2 ||
        seq[4] != 3 || gaps_bad != 0) begin
      n_err++; $display("FAIL loop_sequence: strobes=%0d badgaps=%0d want 5 strobes idx 2,3,1,2,3 every 4",
                        seq.size(), gaps_bad);
    end
    cmd_stop = 1; tick();
  endtask

  task automatic test_done();
    bit found = 0;
    loop_start = 1; loop_end = 3; loop_en = 0; cmd_play = 1; tick();
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL done_cycle%0d: got %h want %h", c, dut_vec, exp_vec());
      end
      if (state == S_DONE) found = 1;
    end
    n_cmp++;
    if (!found || note_idx !== 9'd3) begin
      n_err++; $display("FAIL done_reach: found=%0d idx=%0d want DONE at 3", found, note_idx);
    end
    tick();
    n_cmp++;
    if (tone_out !== 16'h0 || state !== S_DONE) begin
      n_err++; $display("FAIL done_silence: tone=%h state=%0d want 0/3", tone_out, state);
    end
    for (int c = 0; c < 5; c++) tick();
    n_cmp++;
    if (note_idx !== 9'd3 || step_strobe !== 1'b0) begin
      n_err++; $display("FAIL done_hold: idx=%0d stb=%0d want 3/0", note_idx, step_strobe);
    end
    cmd_play = 1; tick();
    n_cmp++;
    if (state !== S_PLAY || note_idx !== 9'd1) begin
      n_err++; $display("FAIL done_restart: state=%0d idx=%0d want 1/1", state, note_idx);
    end
    cmd_stop = 1; tick();
  endtask

  task automatic test_pause();
    logic [8:0] idx_p;
    int first = -1;
    loop_start = 1; loop_end = 3; loop_en = 1; cmd_play = 1; tick();
    tick(); tick();
    cmd_pause = 1; tick();
    idx_p = note_idx;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (state !== S_PAUSE || step_strobe !== 1'b0 || note_idx !== idx_p || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL pause_frozen%0d: got %h want %h", c, dut_vec, exp_vec());
      end
    end
    cmd_play = 1; tick();
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL pause_resume%0d: got %h want %h", c, dut_vec, exp_vec());
      end
      if (step_strobe && first < 0) first = c;
    end
    n_cmp++;
    if (first != 2) begin
      n_err++; $display("FAIL pause_strobe_delay: got %0d want 2", first);
    end
    cmd_stop = 1; tick();
  endtask

  task automatic test_cmd_priority();
    loop_start = 1; loop_end = 3; loop_en = 1; cmd_play = 1; tick();
    tick(); tick();
    cmd_play = 1; cmd_pause = 1; cmd_stop = 1; tick();
    n_cmp++;
    if (state !== S_IDLE || note_idx !== 9'd0) begin
      n_err++; $display("FAIL prio_stop: state=%0d idx=%0d want 0/0", state, note_idx);
    end
    loop_start = 5; loop_end = 2; cmd_play = 1; tick();
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (state !== S_IDLE || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL prio_bad_window%0d: got %h want %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_key_override();
    song_fixed = 1;
    loop_start = 1; loop_end = 3; loop_en = 1; cmd_play = 1; tick();
    tick(); tick();
    n_cmp++;
    if (tone_out !== 16'h1234 || tone_src !== 1'b0) begin
      n_err++; $display("FAIL key_song_tone: tone=%h src=%0d want 1234/0", tone_out, tone_src);
    end
    key_req = 1; key_tone = 16'h0ABC;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (tone_out !== 16'h0ABC || tone_src !== 1'b1 || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL key_override%0d: got %h want %h", c, dut_vec, exp_vec());
      end
    end
    key_req = 0; tick();
    n_cmp++;
    if (tone_out !== 16'h1234 || tone_src !== 1'b0 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL key_release: got %h want %h", dut_vec, exp_vec());
    end
    song_fixed = 0;
    cmd_stop = 1; tick();
  endtask

  task automatic test_tempo_change();
    int pos[$];
    bit found = 0;
    loop_start = 1; loop_end = 3; loop_en = 1; cmd_play = 1; tick();
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (step_strobe) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL tempo_first_strobe: none in 10 cycles");
    end
    tempo_period = 24'd1; tempo_load = 1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL tempo_cycle%0d: got %h want %h", c, dut_vec, exp_vec());
      end
      if (step_strobe) pos.push_back(c);
    end
    n_cmp++;
    if (pos.size() < 3 || pos[0] != 4 || pos[1] != 6 || pos[2] != 8) begin
      n_err++; $display("FAIL tempo_clamp_gaps: strobes=%0d first=%0d want at 4,6,8",
                        pos.size(), (pos.size() > 0) ? pos[0] : -1);
    end
    reset = 1; tick(); reset = 0;
    n_cmp++;
    if (dut_vec !== 29'd0) begin
      n_err++; $display("FAIL tempo_reset_midplay: got %h want 0", dut_vec);
    end
    cmd_play = 1; tick();
    for (int c = 0; c < 30; c++) begin
      tick();
      n_cmp++;
      if (step_strobe !== 1'b0 || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL tempo_default%0d: got %h want %h", c, dut_vec, exp_vec());
      end
    end
    cmd_stop = 1; tick();
  endtask

  task automatic test_random();
    int errs = 0;
    tempo_period = 24'd3; tempo_load = 1; tick();
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 499) == 0);
      cmd_play   = ($urandom_range(0, 99) < 8);
      cmd_pause  = ($urandom_range(0, 99) < 4);
      cmd_stop   = ($urandom_range(0, 99) < 3);
      tempo_load = ($urandom_range(0, 99) < 5);
      tempo_period = 24'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) begin
        loop_start = 9'($urandom_range(0, 7));
        loop_end   = 9'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 19) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 9) == 0) key_req = ~key_req;
      key_tone = 16'($urandom);
      tick();
      reset = 0;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; errs++;
        if (errs <= 10) $display("FAIL random_cycle%0d: got %h want %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1; cmd_play = 0; cmd_pause = 0; cmd_stop = 0; loop_en = 0; tempo_load = 0;
    key_req = 0; key_tone = 0; loop_start = 0; loop_end = 0; tempo_period = 0; song_fixed = 0;
    ms = S_IDLE; midx = 0; mstart = 0; mend = 0; mstb = 0; msrc = 0; mtone = 0;
    mrem = 0; mper = 12500000; mshadow = 12500000;
    #2;
    test_reset();
    test_loop();
    test_done();
    test_pause();
    test_cmd_priority();
    test_key_override();
    test_tempo_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
